multi_composer: RTL
===================

MULTI_COMPOSER -- requirements
Module: multi_composer

Interface
REQ-001 Parameter NUM_LAYERS, default 2, number of tile layers composed (legal 1..4).
REQ-002 Parameter LB_AW, default 10, line-buffer index width.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 regs_addr  input  3  register select; regs_wrdata input 8; regs_write input 1 write strobe; regs_rddata output 8 combinational readback.
REQ-006 line_idx  input  9  current display line; display_start_of_line input 1; display_next_pixel input 1 pixel strobe.
REQ-007 line_idx_out  output  9  line to render (= line_idx); line_render_start output 1 start pulse to all renderers.
REQ-008 layer_enabled  input  NUM_LAYERS  per-layer enable; layer_lb_rddata input NUM_LAYERS*8 layer k pixel in bits [8k+7:8k].
REQ-009 sprites_enabled  input  1; sprites_lb_rddata input 16 ([7:0] colour, [10:8] z).
REQ-010 lb_rdidx  output  LB_AW  shared read index for all line buffers.
REQ-011 sprites_lb_wridx  output  LB_AW; sprites_lb_wrdata output 16 constant 0; sprites_lb_wren output 1 clear strobe.
REQ-012 display_data  output  8  registered palette index; display_mode output 2 (= CTRL.mode).

Function
REQ-013 Registers: 0 CTRL mode[1:0] (rst 0); 1 BORDER (rst 0x00); 2 HSCALE (rst 128, 1.7 fixed step); 3 HSTART (rst 0, pixel = value*4); 4 HSTOP (rst 160, pixel = value*4); addr 5-7 read 0, writes ignored.
REQ-014 line_render_start is display_start_of_line delayed exactly 1 clk.
REQ-015 pix_x (10 bit) clears on display_start_of_line, increments on each display_next_pixel, saturates at 1023.
REQ-016 Window active when HSTART*4 <= pix_x < HSTOP*4; HSTOP <= HSTART means no active pixels.
REQ-017 acc (LB_AW+7 bit) clears on start_of_line; on a pixel strobe inside the window acc += HSCALE, saturating at all-ones; lb_rdidx = acc[LB_AW+6:7].
REQ-018 Line-buffer read data is valid the cycle after lb_rdidx changes; sampled only on display_next_pixel.
REQ-019 On display_next_pixel: display_data <= 0 if mode==0; else BORDER if outside window; else composite.
REQ-020 Composite, lowest to highest priority: 0; sprite with z==1; layer 0; sprite z==2; layer 1; ...; layer NUM_LAYERS-1; sprite z==NUM_LAYERS+1; each term drawn only if enabled and colour != 0; sprite z==0 or z>NUM_LAYERS+1 never drawn.
REQ-021 display_data latency: 1 pixel strobe after its lb_rdidx was presented.
REQ-022 Sprite clear: when a strobe changes lb_rdidx integer part, next cycle sprites_lb_wren=1 for exactly 1 clk with sprites_lb_wridx = previous lb_rdidx; HSCALE<128 therefore clears each entry once, after its last read.
REQ-023 start_of_line and next_pixel in same cycle: start_of_line wins; no increment, no clear write.
REQ-024 Register write during active line takes effect from the next pixel strobe; no glitch on display_data between strobes.
REQ-025 HSCALE=0 holds lb_rdidx at 0 for the line (legal, no clear writes).

Reset
REQ-026 rst asserted anytime, including mid-line: all registers to REQ-013 values, pix_x=0, acc=0, display_data=0, sprites_lb_wren=0, sprites_lb_wridx=0, line_render_start=0.
REQ-027 After rst deassert, no output activity until first display_start_of_line other than combinational readback.

Structure
REQ-028 Shared package holds register address constants, HSCALE_ONE=128, sprite z field bounds, reset values.
REQ-029 One combinational sub-module, layer_prio_mux, implements REQ-020 for parameter NUM_LAYERS.

Verification
REQ-030 rst, read all registers -> 0x00,0x00,0x80,0x00,0xA0; display_mode=0.
REQ-031 mode=1, NUM_LAYERS=2, layer0=0x11, layer1=0x22, sprite colour 0x33 z=2 -> 0x22; z=3 -> 0x33; layer1 disabled, z=2 -> 0x33.
REQ-032 HSTART=4, HSTOP=8, BORDER=0x5A -> pixels 0-15 and 32+ output 0x5A, pixels 16-31 composite.
REQ-033 HSCALE=64 over 8 strobes -> lb_rdidx 0,0,1,1,2,2,3,3; exactly 4 clear writes at indices 0,1,2,3.
REQ-034 rst pulsed mid-line at pix_x=300 -> display_data=0, wren low, next start_of_line restarts at lb_rdidx 0.
REQ-035 start_of_line coincident with next_pixel -> pix_x=0, no wren pulse, line_render_start high next clk.

Source files
------------

// File: rtl/multi_composer_pkg.sv
// Shared constants for the multi-layer line composer: register map,
// reset values, scaling unit and sprite depth field layout.
package multi_composer_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_BORDER = 3'd1;
    localparam logic [2:0] ADDR_HSCALE = 3'd2;
    localparam logic [2:0] ADDR_HSTART = 3'd3;
    localparam logic [2:0] ADDR_HSTOP  = 3'd4;

    localparam logic [7:0] HSCALE_ONE  = 8'd128;
    localparam logic [1:0] RST_MODE    = 2'd0;
    localparam logic [7:0] RST_BORDER  = 8'h00;
    localparam logic [7:0] RST_HSCALE  = HSCALE_ONE;
    localparam logic [7:0] RST_HSTART  = 8'd0;
    localparam logic [7:0] RST_HSTOP   = 8'd160;

    localparam logic [2:0] SPR_Z_MIN   = 3'd1;
    localparam int         SPR_Z_LSB   = 8;
    localparam int         SPR_Z_MSB   = 10;

    function automatic logic [2:0] spr_z(input logic [10:0] spr);
        return spr[SPR_Z_MSB:SPR_Z_LSB];
    endfunction

endpackage

// File: rtl/multi_composer_layer_prio_mux.sv
// Combinational priority mux: sprite interleaved between tile layers by z.
module layer_prio_mux
    import multi_composer_pkg::*;
#(
    parameter int NUM_LAYERS = 2
) (
    input  logic [NUM_LAYERS-1:0]   layer_enabled,
    input  logic [NUM_LAYERS*8-1:0] layer_data,
    input  logic                    sprites_enabled,
    input  logic [10:0]             sprite_data,
    output logic [7:0]              pix
);

    logic [2:0] z_s;
    logic [7:0] spr_col_s;
    logic       spr_vis_s;

    assign z_s       = spr_z(sprite_data);
    assign spr_col_s = sprite_data[7:0];
    assign spr_vis_s = sprites_enabled && (spr_col_s != 8'h00);

    // Paint from lowest to highest priority; a later term overrides.
    always_comb begin
        pix = 8'h00;
        pix = (spr_vis_s && (z_s == SPR_Z_MIN)) ? spr_col_s : pix;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            pix = (layer_enabled[k] && (layer_data[8*k +: 8] != 8'h00)) ? layer_data[8*k +: 8] : pix;
            pix = (spr_vis_s && (z_s == 3'(k + 2))) ? spr_col_s : pix;
        end
    end

endmodule

// File: rtl/multi_composer.sv
// Line composer: register block, horizontal scaler/window, sprite buffer
// clearing and registered palette index output.
module multi_composer
    import multi_composer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int LB_AW      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              regs_addr,
    input  logic [7:0]              regs_wrdata,
    input  logic                    regs_write,
    output logic [7:0]              regs_rddata,
    input  logic [8:0]              line_idx,
    input  logic                    display_start_of_line,
    input  logic                    display_next_pixel,
    output logic [8:0]              line_idx_out,
    output logic                    line_render_start,
    input  logic [NUM_LAYERS-1:0]   layer_enabled,
    input  logic [NUM_LAYERS*8-1:0] layer_lb_rddata,
    input  logic                    sprites_enabled,
    input  logic [15:0]             sprites_lb_rddata,
    output logic [LB_AW-1:0]        lb_rdidx,
    output logic [LB_AW-1:0]        sprites_lb_wridx,
    output logic [15:0]             sprites_lb_wrdata,
    output logic                    sprites_lb_wren,
    output logic [7:0]              display_data,
    output logic [1:0]              display_mode
);

    localparam int ACC_W = LB_AW + 7;

    logic [1:0]       mode_r;
    logic [7:0]       border_r, hscale_r, hstart_r, hstop_r;
    logic [9:0]       pix_x_r;
    logic [ACC_W-1:0] acc_r, acc_next_s;
    logic [ACC_W:0]   sum_s;
    logic             started_r, strobe_s, in_win_s;
    logic [7:0]       comp_s;
    logic [4:0]       unused_spr_s;

    assign unused_spr_s      = sprites_lb_rddata[15:11];
    assign line_idx_out      = line_idx;
    assign display_mode      = mode_r;
    assign sprites_lb_wrdata = 16'h0000;
    assign lb_rdidx          = acc_r[ACC_W-1:7];

    // Strobes before the first start of line after reset are ignored.
    assign strobe_s   = started_r && display_next_pixel && !display_start_of_line;
    assign in_win_s   = (pix_x_r >= {hstart_r, 2'b00}) && (pix_x_r < {hstop_r, 2'b00});
    assign sum_s      = {1'b0, acc_r} + (ACC_W + 1)'(hscale_r);
    assign acc_next_s = sum_s[ACC_W] ? {ACC_W{1'b1}} : sum_s[ACC_W-1:0];

    layer_prio_mux #(.NUM_LAYERS(NUM_LAYERS)) u_prio (
        .layer_enabled   (layer_enabled),
        .layer_data      (layer_lb_rddata),
        .sprites_enabled (sprites_enabled),
        .sprite_data     (sprites_lb_rddata[10:0]),
        .pix             (comp_s)
    );

    // Combinational register readback.
    always_comb begin
        regs_rddata = 8'h00;
        case (regs_addr)
            ADDR_CTRL:   regs_rddata = {6'd0, mode_r};
            ADDR_BORDER: regs_rddata = border_r;
            ADDR_HSCALE: regs_rddata = hscale_r;
            ADDR_HSTART: regs_rddata = hstart_r;
            ADDR_HSTOP:  regs_rddata = hstop_r;
            default:     regs_rddata = 8'h00;
        endcase
    end

    // Register file writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r   <= RST_MODE;
            border_r <= RST_BORDER;
            hscale_r <= RST_HSCALE;
            hstart_r <= RST_HSTART;
            hstop_r  <= RST_HSTOP;
        end else if (regs_write) begin
            case (regs_addr)
                ADDR_CTRL:   mode_r   <= regs_wrdata[1:0];
                ADDR_BORDER: border_r <= regs_wrdata;
                ADDR_HSCALE: hscale_r <= regs_wrdata;
                ADDR_HSTART: hstart_r <= regs_wrdata;
                ADDR_HSTOP:  hstop_r  <= regs_wrdata;
                default:     mode_r   <= mode_r;
            endcase
        end
    end

    // Pixel position, scaler accumulator, output pixel and sprite clear strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_r         <= 1'b0;
            line_render_start <= 1'b0;
            pix_x_r           <= 10'd0;
            acc_r             <= '0;
            display_data      <= 8'h00;
            sprites_lb_wren   <= 1'b0;
            sprites_lb_wridx  <= '0;
        end else begin
            line_render_start <= display_start_of_line;
            sprites_lb_wren   <= 1'b0;
            if (display_start_of_line) begin
                started_r <= 1'b1;
                pix_x_r   <= 10'd0;
                acc_r     <= '0;
            end else if (strobe_s) begin
                pix_x_r <= (pix_x_r == 10'h3FF) ? pix_x_r : pix_x_r + 10'd1;
                if (mode_r == 2'd0) begin
                    display_data <= 8'h00;
                end else if (!in_win_s) begin
                    display_data <= border_r;
                end else begin
                    display_data <= comp_s;
                end
                if (in_win_s) begin
                    acc_r <= acc_next_s;
                    if (acc_next_s[ACC_W-1:7] != lb_rdidx) begin
                        sprites_lb_wren  <= 1'b1;
                        sprites_lb_wridx <= lb_rdidx;
                    end
                end
            end
        end
    end

endmodule
